data_bus_master: RTL and testbench
==================================

# data_bus_master

Bus initiator between the pipeline memory stage and the shared data bus (main memory, on-chip FP unit, IO devices). It takes one load/store request at a time from the pipeline and drives `ReadData`/`WriteData`/`DataAddr`/`BusIn` toward the bus. It waits for the addressed device's `DataDone`, then captures `BusOut` and returns a single-cycle response to the pipeline. It handles both zero-wait devices, which assert done combinationally, and multi-cycle devices whose done toggles while the strobe is held.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of strobe cycles allowed before abort. Used only with `BUS_TIMEOUT_EN`. Legal range is 1–255.
- `Clock` input, 1 bit: the single clock. All logic is rising-edge.
- `Reset` input, 1 bit: synchronous, active-low. Sampled on the rising edge of `Clock`.
- `ReqValid` input, 1 bit: the pipeline presents a request.
- `ReqWrite` input, 1 bit: 1 selects a store, 0 selects a load.
- `ReqAddr` input, 16 bits: request address. Bits [15:12] select the device and bits [11:8] select the sub-device.
- `ReqData` input, 16 bits: store data.
- `ReqReady` output, 1 bit: the master can accept a request this cycle.
- `RespValid` output, 1 bit: one-cycle pulse signalling that the transaction completed.
- `RespData` output, 16 bits: load data. It is 0 for stores and timeouts.
- `RespErr` output, 1 bit: the transaction was aborted by timeout. Valid together with `RespValid`.
- `ReadData` output, 1 bit: bus read strobe.
- `WriteData` output, 1 bit: bus write strobe.
- `DataAddr` output, 16 bits: bus address.
- `BusIn` output, 16 bits: bus write data.
- `BusOut` input, 16 bits: bus read data.
- `DataDone` input, 1 bit: the device has completed the access.

## Operation
The master is a state machine with three states: IDLE, BUS and RESP.

- **IDLE**
  - `ReqReady`=1 and both strobes are 0.
  - When `ReqValid`=1, the master latches `ReqAddr`/`ReqData`/`ReqWrite` into its holding registers and moves to BUS.
- **BUS**
  - `ReadData`=~write_q and `WriteData`=write_q.
  - `DataAddr`/`BusIn` come from the holding registers and stay stable for the whole state.
  - `ReqReady`=0.
  - When `DataDone`=1 is sampled, the master captures `BusOut` into the response register (loads only; stores capture 0) and moves to RESP.
- **RESP**
  - Both strobes are 0 and `RespValid`=1 for exactly one cycle.
  - `ReqReady`=0.
  - The master always moves to IDLE next.
  - This forces at least one strobe-low cycle between transactions, which clears toggling device done flags.
- **Exactly one strobe**
  - Never both strobes high.
  - Strobes are high only in BUS.
- **Unmapped device**
  - The bus returns `DataDone`=1 and `BusOut`=0 for unmapped devices.
  - The master completes these normally, returning `RespData`=0 with `RespErr`=0.
- **Held responses**
  - `RespData`/`RespErr` hold their values until the next `RespValid`.
  - Both are 0 after reset.
- **`ReqValid` outside IDLE**
  - `ReqValid` is ignored outside IDLE.
  - The pipeline must hold the request until it sees `ReqReady`=1.

## Timing
- **Reset**
  - `Reset`=0 at an edge forces IDLE and clears the holding registers, response registers and timeout counter.
  - After that edge: strobes=0, `DataAddr`=0, `BusIn`=0, `RespValid`=0, `RespData`=0, `RespErr`=0, `ReqReady`=1.
  - Reset mid-BUS drops the strobes on the next cycle and produces no response.
- **Zero-wait device** (done combinational):
  - Cycle 0: accepting edge.
  - Cycle 1: strobe high; done sampled at the end of this cycle.
  - Cycle 2: `RespValid`.
  - Cycle 3: IDLE.
- **Memory** (done asserted one edge after the strobe):
  - Strobe high for 2 cycles.
  - `RespValid` in cycle 3.
  - Data is captured on the same edge that samples done.
- **Throughput**: peak is one transaction per 3 cycles.
- **Simultaneous events**: `DataDone` and a timeout on the same edge resolve as completion, not error.

## Configuration
- **`BUS_TIMEOUT_EN` defined**
  - An 8-bit counter clears on entering BUS and increments on each BUS cycle with `DataDone`=0.
  - When the counter reaches `TIMEOUT_CYCLES` and done is still 0, the master moves to RESP with `RespErr`=1 and `RespData`=0.
  - On timeout, the strobes drop after exactly `TIMEOUT_CYCLES` high cycles.
- **`BUS_TIMEOUT_EN` not defined**
  - No counter is built.
  - BUS waits indefinitely.
  - `RespErr` is tied to 0.

## Test plan
- **IO read of SW**: `ReqAddr`=16'h2100, SW=10'h2A5, done combinational → `ReadData` high 1 cycle, `RespValid` 2 cycles after accept, `RespData`=16'h02A5, `RespErr`=0.
- **Memory write then read**: write `ReqAddr`=16'h0010 with `ReqData`=16'hBEEF, then read 16'h0010 → each strobe high 2 cycles, read `RespData`=16'hBEEF, strobes low ≥1 cycle between the two transactions.
- **`ReqValid` held continuously with 3 queued IO writes to 16'h2200** → `ReqReady` low during BUS/RESP, exactly 3 `RespValid` pulses 3 cycles apart, never both strobes high.
- **Timeout**: `BUS_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=4, `DataDone` held 0 → strobe high exactly 4 cycles, `RespValid` with `RespErr`=1 and `RespData`=0. With the macro undefined, the strobe stays high for 100+ cycles with no response.
- **Reset mid-operation**: `Reset`=0 during BUS of a memory read → strobes 0 on the next cycle, no `RespValid`, `ReqReady`=1 after release, next request completes normally.
- **Unmapped device**: `ReqAddr`=16'hF000 read → `RespValid` in cycle 2, `RespData`=0, `RespErr`=0.

Source files
------------

// File: rtl/data_bus_master.sv
// data_bus_master: single-outstanding load/store initiator between the pipeline memory stage and the shared data bus
// Optional feature macro: BUS_TIMEOUT_EN (aborts a bus access after TIMEOUT_CYCLES strobe cycles without DataDone)
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-low reset
//   ReqValid/ReqWrite/ReqAddr/ReqData/ReqReady   pipeline request side
//   RespValid/RespData/RespErr                   pipeline response side (one-cycle pulse, held data/err)
//   ReadData/WriteData/DataAddr/BusIn            bus strobes, address and write data
//   BusOut/DataDone                              bus read data and device completion
module data_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [15:0] ReqAddr,
    input  logic [15:0] ReqData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [15:0] RespData,
    output logic        RespErr,
    output logic        ReadData,
    output logic        WriteData,
    output logic [15:0] DataAddr,
    output logic [15:0] BusIn,
    input  logic [15:0] BusOut,
    input  logic        DataDone
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;
    logic   write_q;
`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt;
    logic       tmo;
    // cnt holds the number of already-elapsed done-less strobe cycles
    assign tmo = !DataDone && cnt == 8'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = |8'(TIMEOUT_CYCLES);
    assign RespErr = 1'b0;
`endif
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            DataAddr  <= '0;
            BusIn     <= '0;
            ReadData  <= 1'b0;
            WriteData <= 1'b0;
            ReqReady  <= 1'b1;
            RespValid <= 1'b0;
            RespData  <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt       <= '0;
            RespErr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (ReqValid) begin
                    state     <= BUS;
                    write_q   <= ReqWrite;
                    DataAddr  <= ReqAddr;
                    BusIn     <= ReqData;
                    ReadData  <= !ReqWrite;
                    WriteData <= ReqWrite;
                    ReqReady  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                BUS: begin
                    // completion wins over a coincident timeout
                    if (DataDone) begin
                        state     <= RESP;
                        ReadData  <= 1'b0;
                        WriteData <= 1'b0;
                        RespValid <= 1'b1;
                        RespData  <= write_q ? 16'h0 : BusOut;
`ifdef BUS_TIMEOUT_EN
                        RespErr   <= 1'b0;
                    end else if (tmo) begin
                        state     <= RESP;
                        ReadData  <= 1'b0;
                        WriteData <= 1'b0;
                        RespValid <= 1'b1;
                        RespData  <= '0;
                        RespErr   <= 1'b1;
                    end else begin
                        cnt       <= cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    RespValid <= 1'b0;
                    ReqReady  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    ReadData  <= 1'b0;
                    WriteData <= 1'b0;
                    RespValid <= 1'b0;
                    ReqReady  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_master.sv
// tb_data_bus_master: scoreboard bench for data_bus_master with memory, IO, hanging and unmapped device models
module tb_data_bus_master;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [15:0] ReqAddr = '0;
    logic [15:0] ReqData = '0;
    logic        ReqReady, RespValid, RespErr, ReadData, WriteData, DataDone;
    logic [15:0] RespData, DataAddr, BusIn, BusOut;

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] sb[$];

    logic [15:0] mem[0:255];
    logic        mem_done = 1'b0;
    logic [9:0]  sw = 10'h2A5;
    logic [9:0]  led = '0;
    int          led_cnt = 0;

    data_bus_master #(.TIMEOUT_CYCLES(4)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqReady(ReqReady), .RespValid(RespValid),
        .RespData(RespData), .RespErr(RespErr), .ReadData(ReadData), .WriteData(WriteData),
        .DataAddr(DataAddr), .BusIn(BusIn), .BusOut(BusOut), .DataDone(DataDone)
    );

    always #5 Clock = ~Clock;

    // device 0: memory (done one edge after strobe), 2: IO (combinational done, SW at 21xx, LED at 22xx),
    // 3: device that never answers, others: unmapped (done=1, data=0)
    always_comb begin
        DataDone = 1'b0;
        BusOut   = 16'h0;
        case (DataAddr[15:12])
            4'h0: begin DataDone = mem_done; BusOut = mem[DataAddr[7:0]]; end
            4'h2: begin DataDone = ReadData | WriteData; BusOut = (DataAddr[11:8] == 4'h1) ? {6'b0, sw} : 16'h0; end
            4'h3: begin DataDone = 1'b0; BusOut = 16'hDEAD; end
            default: begin DataDone = ReadData | WriteData; BusOut = 16'h0; end
        endcase
    end

    always @(posedge Clock) begin
        mem_done <= (ReadData | WriteData) && DataAddr[15:12] == 4'h0 && !mem_done;
        if (WriteData && DataDone && DataAddr[15:12] == 4'h0) mem[DataAddr[7:0]] <= BusIn;
        if (WriteData && DataDone && DataAddr[15:8] == 8'h22) begin
            led     <= BusIn[9:0];
            led_cnt <= led_cnt + 1;
        end
    end

    always @(negedge Clock) begin
        if (ReadData && WriteData) begin
            vectors++; miscompares++;
            $display("FAIL both_strobes: ReadData=%b WriteData=%b, required at most one high", ReadData, WriteData);
        end
        if (RespValid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp: got RespValid with data=%h err=%b, required no response", RespData, RespErr);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                if ({RespErr, RespData} !== e) begin
                    miscompares++;
                    $display("FAIL resp: got err=%b data=%h, required err=%b data=%h", RespErr, RespData, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        @(negedge Clock);
        for (int k = 0; k < 50 && ReqReady !== 1'b1; k++) @(negedge Clock);
        vectors++;
        if (ReqReady !== 1'b1 || ReadData || WriteData) begin
            miscompares++;
            $display("FAIL %s_ready: ReqReady=%b strobes=%b%b, required ready with strobes 00", name, ReqReady, ReadData, WriteData);
        end
    endtask

    task automatic run_txn(input string name, input logic w, input logic [15:0] a, input logic [15:0] d,
                           input logic push, input logic [16:0] e, input int es, input int er);
        int st, rc, bad;
        wait_ready(name);
        ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqData = d;
        if (push) sb.push_back(e);
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        st = 0; rc = 0; bad = 0;
        for (int k = 1; k <= 40 && rc == 0; k++) begin
            @(negedge Clock);
            if (ReadData | WriteData) begin
                st++;
                if (WriteData !== w || ReadData !== !w || DataAddr !== a || (w && BusIn !== d)) bad++;
            end
            if (RespValid) rc = k;
        end
        vectors += 3;
        if (st != es) begin miscompares++; $display("FAIL %s_strobe_cycles: got %0d, required %0d", name, st, es); end
        if (rc != er) begin miscompares++; $display("FAIL %s_resp_cycle: got %0d, required %0d", name, rc, er); end
        if (bad != 0) begin miscompares++; $display("FAIL %s_bus_drive: %0d bad strobe cycles, required 0", name, bad); end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        vectors++;
        if ({ReadData, WriteData, DataAddr, BusIn, RespValid, RespData, RespErr, ReqReady} !== {34'h0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state: rd=%b wr=%b addr=%h busin=%h rv=%b rd=%h err=%b rdy=%b, required all 0 and rdy=1",
                     ReadData, WriteData, DataAddr, BusIn, RespValid, RespData, RespErr, ReqReady);
        end
    endtask

    task automatic test_io();
        sw = 10'h2A5;
        run_txn("io_read_sw", 1'b0, 16'h2100, 16'h0, 1'b1, {1'b0, 16'h02A5}, 1, 2);
        sw = 10'h155;
        run_txn("io_read_sw2", 1'b0, 16'h2180, 16'h0, 1'b1, {1'b0, 16'h0155}, 1, 2);
        run_txn("io_store_zero", 1'b1, 16'h2100, 16'h1234, 1'b1, {1'b0, 16'h0000}, 1, 2);
    endtask

    task automatic test_mem();
        run_txn("mem_write", 1'b1, 16'h0010, 16'hBEEF, 1'b1, 17'h0, 2, 3);
        run_txn("mem_read", 1'b0, 16'h0010, 16'h0, 1'b1, {1'b0, 16'hBEEF}, 2, 3);
        run_txn("mem_write2", 1'b1, 16'h0022, 16'h5A5A, 1'b1, 17'h0, 2, 3);
        run_txn("mem_read2", 1'b0, 16'h0022, 16'h0, 1'b1, {1'b0, 16'h5A5A}, 2, 3);
        repeat (3) @(negedge Clock);
        vectors++;
        if (RespData !== 16'h5A5A || RespErr !== 1'b0) begin
            miscompares++;
            $display("FAIL held_resp: got data=%h err=%b, required data=5a5a err=0", RespData, RespErr);
        end
    endtask

    task automatic test_back_to_back();
        int sent, n, last, gap_bad, rdy_bad, led0;
        sent = 0; n = 0; last = 0; gap_bad = 0; rdy_bad = 0; led0 = led_cnt;
        wait_ready("b2b");
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'h2200; ReqData = 16'h0001;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge Clock);
            if (sent == 3) ReqValid = 1'b0;
            else ReqData = 16'(sent + 1);
            if (RespValid) begin
                if (n > 0 && c - last != 3) gap_bad++;
                n++; last = c;
            end
            if (ReqReady && (ReadData || WriteData || RespValid)) rdy_bad++;
            if (ReqReady && ReqValid) begin sb.push_back(17'h0); sent++; end
        end
        vectors += 5;
        if (n != 3) begin miscompares++; $display("FAIL b2b_count: got %0d responses, required 3", n); end
        if (gap_bad != 0) begin miscompares++; $display("FAIL b2b_spacing: %0d bad gaps, required 0", gap_bad); end
        if (rdy_bad != 0) begin miscompares++; $display("FAIL b2b_ready: ReqReady high in BUS/RESP %0d times, required 0", rdy_bad); end
        if (led_cnt - led0 != 3) begin miscompares++; $display("FAIL b2b_led_writes: got %0d, required 3", led_cnt - led0); end
        if (led !== 10'h003) begin miscompares++; $display("FAIL b2b_led_value: got %h, required 003", led); end
    endtask

    task automatic test_timeout();
`ifdef BUS_TIMEOUT_EN
        run_txn("timeout", 1'b0, 16'h3000, 16'h0, 1'b1, {1'b1, 16'h0000}, 4, 5);
        run_txn("after_timeout", 1'b0, 16'h2100, 16'h0, 1'b1, {1'b0, 6'b0, sw}, 1, 2);
`else
        int st;
        wait_ready("hang");
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'h3000;
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        st = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge Clock);
            if (ReadData) st++;
        end
        vectors++;
        if (st != 120) begin miscompares++; $display("FAIL hang_strobe: high %0d of 120 cycles, required 120", st); end
        Reset = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1;
`endif
    endtask

    task automatic test_reset_mid();
        run_txn("mid_reset_prep", 1'b1, 16'h0040, 16'hCAFE, 1'b1, 17'h0, 2, 3);
        wait_ready("mid_reset");
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'h0040;
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        vectors++;
        if (ReadData || WriteData || RespValid) begin
            miscompares++;
            $display("FAIL mid_reset_drop: strobes=%b%b rv=%b, required 000", ReadData, WriteData, RespValid);
        end
        Reset = 1'b1;
        @(negedge Clock);
        vectors++;
        if (ReqReady !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b, required 1", ReqReady); end
        repeat (3) @(negedge Clock);
        run_txn("after_reset", 1'b0, 16'h0040, 16'h0, 1'b1, {1'b0, 16'hCAFE}, 2, 3);
    endtask

    task automatic test_unmapped();
        run_txn("unmapped_read", 1'b0, 16'hF000, 16'h0, 1'b1, 17'h0, 1, 2);
        run_txn("unmapped_write", 1'b1, 16'hA123, 16'h7777, 1'b1, 17'h0, 1, 2);
    endtask

    initial begin
        test_reset();
        test_io();
        test_mem();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_unmapped();
        repeat (3) @(negedge Clock);
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL missing_resp: %0d expected responses never arrived", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
